sha2_w_sched_stage: RTL

Parametrised SHA-2 message-schedule pipeline stage for the mining datapath. It holds a 16-word sliding W window and produces STEPS new schedule words per stage, W[t..t+STEPS-1]. The window is shifted by STEPS and registered behind a valid/ready handshake. Chained instances cover rounds 16..63 (SHA-256) or 16..79 (SHA-512) and feed the compression pipeline.

---
 rtl/sha2_w_sched_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sha2_w_sched_stage.sv
// SHA-2 message-schedule pipeline stage.
// Takes a 16-word sliding W window and produces STEPS new schedule words
// W[t..t+STEPS-1]. It returns the window shifted by STEPS. The result sits
// in a single output register behind a valid/ready handshake.
module sha2_w_sched_stage #(
  parameter  int MODE  = 0,
  parameter  int STEPS = 1,
  parameter  int TAG_W = 8,
  localparam int W     = (MODE != 0) ? 64 : 32,
  localparam int NR    = (MODE != 0) ? 80 : 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*W-1:0]      in_window,
  input  logic [6:0]           in_round,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*W-1:0]      out_window,
  output logic [STEPS*W-1:0]   out_wt,
  output logic [6:0]           out_round,
  output logic                 out_last,
  output logic                 out_err,
  output logic [TAG_W-1:0]     out_tag
);

  // Reject unsupported step counts at elaboration time.
  if (STEPS < 1 || STEPS > 4) begin : g_bad_steps
    $error("sha2_w_sched_stage: STEPS must be in 1..4");
  end

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
    if (MODE != 0) sig0 = rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else           sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
    if (MODE != 0) sig1 = rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else           sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // ext[0..15] is the input window, oldest first.
  // ext[16..] holds the newly generated words.
  logic [W-1:0]       ext [16+STEPS];
  logic [STEPS*W-1:0] wt_new;
  logic [16*W-1:0]    window_new;
  logic [7:0]         round_sum;
  logic [6:0]         round_new;
  logic               err_new;
  logic               last_new;
  logic               accept;

  // Combinational schedule chain.
  // Later words may use earlier words from the same stage as operands.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      ext[j] = in_window[(15-j)*W +: W];
    end
    for (int k = 0; k < STEPS; k++) begin
      ext[16+k] = sig1(ext[14+k]) + ext[9+k] + sig0(ext[1+k]) + ext[k];
    end
    wt_new = '0;
    for (int k = 0; k < STEPS; k++) begin
      wt_new[(STEPS-1-k)*W +: W] = ext[16+k];
    end
    window_new = {in_window[16*W-1-STEPS*W:0], wt_new};
  end

  // Round bookkeeping. The sum is kept at 8 bits so an overflowing
  // range check cannot wrap into a legal-looking value.
  always_comb begin
    round_sum = {1'b0, in_round} + 8'(STEPS);
    round_new = round_sum[6:0];
    err_new   = (in_round < 7'd16) || (round_sum > 8'(NR));
    last_new  = (round_new == 7'(NR));
  end

  logic               valid_q,  valid_d;
  logic [16*W-1:0]    window_q, window_d;
  logic [STEPS*W-1:0] wt_q,     wt_d;
  logic [6:0]         round_q,  round_d;
  logic               last_q,   last_d;
  logic               err_q,    err_d;
  logic [TAG_W-1:0]   tag_q,    tag_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state logic for the output register.
  // Data is held unless a new window is accepted.
  // Valid drops only after a drain that has no replacement.
  always_comb begin
    valid_d  = valid_q;
    window_d = window_q;
    wt_d     = wt_q;
    round_d  = round_q;
    last_d   = last_q;
    err_d    = err_q;
    tag_d    = tag_q;
    if (accept) begin
      valid_d  = 1'b1;
      window_d = window_new;
      wt_d     = wt_new;
      round_d  = round_new;
      last_d   = last_new;
      err_d    = err_new;
      tag_d    = in_tag;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q  <= 1'b0;
      window_q <= '0;
      wt_q     <= '0;
      round_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      window_q <= window_d;
      wt_q     <= wt_d;
      round_q  <= round_d;
      last_q   <= last_d;
      err_q    <= err_d;
      tag_q    <= tag_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_window = window_q;
  assign out_wt     = wt_q;
  assign out_round  = round_q;
  assign out_last   = last_q;
  assign out_err    = err_q;
  assign out_tag    = tag_q;

endmodule
